// File: rtl/mem_arbiter.sv
// Serialises instruction-fetch and load/store accesses onto one req/ack memory bus.
// Data has priority, a streak counter protects fetch from starvation, and a timeout aborts hung accesses.
module mem_arbiter #(
  parameter int XLEN       = 32,
  parameter int MAX_STREAK = 3,
  parameter int TIMEOUT    = 255
) (
  input  logic            clock,
  input  logic            reset,
  // fetch port
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic [31:0]     if_rdata,
  output logic            if_ack,
  // load/store port
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_ack,
  // shared memory bus
  output logic            m_req,
  output logic            m_we,
  output logic [XLEN-1:0] m_addr,
  output logic [XLEN-1:0] m_wdata,
  input  logic [XLEN-1:0] m_rdata,
  input  logic            m_ack,
  // status
  output logic            err,
  output logic            busy,
  output logic [1:0]      dbg_state,
  output logic [3:0]      dbg_streak
);

  // Handshake: a requester raises x_req with its fields stable and holds them until the
  // one-cycle x_ack; m_req is held with m_we/m_addr/m_wdata stable until m_ack or abort.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int         TMO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [15:0] TMO_LAST  = TMO_LAST_I[15:0];
  localparam bit          TMO_EN    = (TIMEOUT != 0);
  localparam logic [3:0]  STREAK_MAX = MAX_STREAK[3:0];

  state_t            state, state_n;
  logic              m_req_n, m_we_n;
  logic [XLEN-1:0]   m_addr_n, m_wdata_n, d_rdata_n;
  logic [31:0]       if_rdata_n;
  logic              if_ack_n, d_ack_n, err_n, busy_n;
  logic [3:0]        streak, streak_n;
  logic [15:0]       tmo, tmo_n;
  logic              fetch_forced;

  assign fetch_forced = if_req && (streak == STREAK_MAX);
  assign dbg_state    = state;
  assign dbg_streak   = streak;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      if_rdata <= '0;
      d_rdata  <= '0;
      if_ack   <= 1'b0;
      d_ack    <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      streak   <= 4'd0;
      tmo      <= 16'd0;
    end else begin
      state    <= state_n;
      m_req    <= m_req_n;
      m_we     <= m_we_n;
      m_addr   <= m_addr_n;
      m_wdata  <= m_wdata_n;
      if_rdata <= if_rdata_n;
      d_rdata  <= d_rdata_n;
      if_ack   <= if_ack_n;
      d_ack    <= d_ack_n;
      err      <= err_n;
      busy     <= busy_n;
      streak   <= streak_n;
      tmo      <= tmo_n;
    end
  end

  always_comb begin
    state_n    = state;
    m_req_n    = 1'b0;
    m_we_n     = m_we;
    m_addr_n   = m_addr;
    m_wdata_n  = m_wdata;
    if_rdata_n = if_rdata;
    d_rdata_n  = d_rdata;
    if_ack_n   = 1'b0;
    d_ack_n    = 1'b0;
    err_n      = 1'b0;
    streak_n   = streak;
    tmo_n      = 16'd0;

    case (state)
      IDLE: begin
        if (d_req && !fetch_forced) begin
          state_n   = GRANT_D;
          m_req_n   = 1'b1;
          m_we_n    = d_we;
          m_addr_n  = d_addr;
          m_wdata_n = d_wdata;
          // Only data grants that make fetch wait extend the streak.
          if (!if_req)
            streak_n = 4'd0;
          else if (streak != STREAK_MAX)
            streak_n = streak + 4'd1;
        end else if (if_req) begin
          state_n   = GRANT_I;
          m_req_n   = 1'b1;
          m_we_n    = 1'b0;
          m_addr_n  = if_addr;
          m_wdata_n = '0;
          streak_n  = 4'd0;
        end
      end

      GRANT_I, GRANT_D: begin
        // m_ack is checked first so a late ack beats the abort in the same cycle.
        if (m_ack) begin
          state_n = DONE;
          if (state == GRANT_I) begin
            if_rdata_n = m_rdata[31:0];
            if_ack_n   = 1'b1;
          end else begin
            if (!m_we) d_rdata_n = m_rdata;
            d_ack_n = 1'b1;
          end
        end else if (TMO_EN && (tmo == TMO_LAST)) begin
          state_n = DONE;
          err_n   = 1'b1;
          if (state == GRANT_I) begin
            if_rdata_n = 32'd0;
            if_ack_n   = 1'b1;
          end else begin
            if (!m_we) d_rdata_n = '0;
            d_ack_n = 1'b1;
          end
        end else begin
          m_req_n = 1'b1;
          tmo_n   = tmo + 16'd1;
        end
      end

      // Ack cycle: no arbitration, so a request still held here is not granted twice.
      DONE: state_n = IDLE;

      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  acks_exclusive: assert property (@(posedge clock) disable iff (reset) !(if_ack && d_ack));
  err_needs_ack:  assert property (@(posedge clock) disable iff (reset) err |-> (if_ack || d_ack));
  req_only_in_grant: assert property (@(posedge clock) disable iff (reset)
                                      m_req |-> (state == GRANT_I || state == GRANT_D));

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter: a transaction-level model predicts grant order, bus timing,
// completion cycle, error and read data of every access; directed sequences cover the corner cases.
module tb_mem_arbiter;

  localparam int XLEN = 32;
  localparam int MS   = 3;
  localparam int T    = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            if_req = 1'b0;
  logic [XLEN-1:0] if_addr = '0;
  logic [31:0]     if_rdata;
  logic            if_ack;
  logic            d_req = 1'b0;
  logic            d_we = 1'b0;
  logic [XLEN-1:0] d_addr = '0;
  logic [XLEN-1:0] d_wdata = '0;
  logic [XLEN-1:0] d_rdata;
  logic            d_ack;
  logic            m_req, m_we;
  logic [XLEN-1:0] m_addr, m_wdata;
  logic [XLEN-1:0] m_rdata = '0;
  logic            m_ack = 1'b0;
  logic            err, busy;
  logic [1:0]      dbg_state;
  logic [3:0]      dbg_streak;

  mem_arbiter #(.XLEN(XLEN), .MAX_STREAK(MS), .TIMEOUT(T)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack),
    .err(err), .busy(busy), .dbg_state(dbg_state), .dbg_streak(dbg_streak)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- scoreboard / model state ----------------
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          g_cyc = 0, a_cyc = 0, free_cyc = 0, mem_ack_cyc = -1;
  int          lat_fixed = 0;
  int          mstreak = 0;
  bit          act = 1'b0, a_err = 1'b0, a_port = 1'b0, a_we = 1'b0;
  bit          use_fixed = 1'b0, f_got = 1'b0, d_got = 1'b0;
  logic [31:0] a_addr = '0, a_wdata = '0, mem_data = '0, data_fixed = '0;
  logic [31:0] exp_if = '0, exp_d = '0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Per-cycle reference: one access at a time; access granted in cycle g with memory latency L
  // holds the bus in cycles g+1..g+min(L,T) and completes in the following cycle.
  task automatic monitor_cycle();
    int          lat;
    bit          in_win, done;
    logic [31:0] rd;
    f_got = if_ack;
    d_got = d_ack;
    if (reset) begin
      act = 1'b0; free_cyc = cyc + 1; mstreak = 0; mem_ack_cyc = -1;
      exp_if = '0; exp_d = '0; exp_q.delete();
      return;
    end
    done = act && (cyc == a_cyc);
    if (done && (!a_port || !a_we)) begin
      rd = exp_q.pop_front();
      if (!a_port) exp_if = rd; else exp_d = rd;
    end
    in_win = act && (cyc > g_cyc) && (cyc < a_cyc);
    check("m_req", m_req, in_win);
    check("busy", busy, act && (cyc > g_cyc));
    check("if_ack", if_ack, done && !a_port);
    check("d_ack", d_ack, done && a_port);
    check("err", err, done && a_err);
    check("if_rdata", if_rdata, exp_if);
    check("d_rdata", d_rdata, exp_d);
    check("streak", dbg_streak, mstreak);
    if (in_win) begin
      check("m_we", m_we, a_we);
      check("m_addr", m_addr, a_addr);
      check("m_wdata", m_wdata, a_wdata);
    end
    if (done) act = 1'b0;
    if (!act && (cyc >= free_cyc) && (if_req || d_req)) begin
      a_port = d_req && !(if_req && (mstreak == MS));
      if (a_port) begin
        a_we = d_we; a_addr = d_addr; a_wdata = d_wdata;
        mstreak = if_req ? ((mstreak + 1 > MS) ? MS : mstreak + 1) : 0;
      end else begin
        a_we = 1'b0; a_addr = if_addr; a_wdata = '0;
        mstreak = 0;
      end
      lat      = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(T + 2, 1));
      mem_data = use_fixed ? data_fixed : $urandom;
      act   = 1'b1;
      g_cyc = cyc;
      if (lat <= T) begin
        a_err = 1'b0; a_cyc = cyc + lat + 1; mem_ack_cyc = cyc + lat;
      end else begin
        a_err = 1'b1; a_cyc = cyc + T + 1; mem_ack_cyc = -1;
      end
      free_cyc = a_cyc + 1;
      if (!a_port || !a_we) exp_q.push_back(a_err ? 32'h0 : mem_data);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clock);
    monitor_cycle();
    @(posedge clock);
    #1;
    cyc++;
    if (cyc == mem_ack_cyc) begin
      m_ack = 1'b1; m_rdata = mem_data;
    end else if (act && (cyc > g_cyc) && (cyc < a_cyc)) begin
      m_ack = 1'b0; m_rdata = $urandom;
    end else begin
      m_ack = ($urandom_range(3) == 0); m_rdata = $urandom;
    end
  endtask

  task automatic drive_reqs(input int f_pct, input int d_pct);
    if (if_req && f_got) if_req = 1'b0;
    if (d_req && d_got) d_req = 1'b0;
    if (!if_req && ($urandom_range(99) < f_pct)) begin
      if_req = 1'b1; if_addr = $urandom & 32'hFFFF_FFFC;
    end
    if (!d_req && ($urandom_range(99) < d_pct)) begin
      d_req = 1'b1; d_we = $urandom_range(1); d_addr = $urandom; d_wdata = $urandom;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      drive_reqs(0, 0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n_d;
    bit seen;

    // reset values
    tick();
    tick();
    check("rst_m_req", m_req, 0);
    check("rst_busy", busy, 0);
    check("rst_if_ack", if_ack, 0);
    check("rst_d_ack", d_ack, 0);
    check("rst_err", err, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_state", dbg_state, 0);
    reset = 1'b0;
    idle(3);

    // single load, zero-wait
    lat_fixed = 1; use_fixed = 1'b1; data_fixed = 32'hDEAD_BEEF;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_wdata = $urandom;
    tick();
    check("load_m_req", m_req, 1);
    tick();
    check("load_d_ack", d_ack, 1);
    check("load_rdata", d_rdata, 32'hDEAD_BEEF);
    check("load_err", err, 0);
    idle(4);

    // simultaneous fetch + store: data first, then fetch
    data_fixed = 32'hA5A5_0001;
    if_req = 1'b1; if_addr = 32'h0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h55;
    tick();
    check("sim_m_we", m_we, 1);
    check("sim_m_addr", m_addr, 32'h200);
    check("sim_m_wdata", m_wdata, 32'h55);
    tick();
    check("sim_d_ack", d_ack, 1);
    check("sim_store_keeps", d_rdata, 32'hDEAD_BEEF);
    tick();
    drive_reqs(0, 0);
    tick();
    check("sim_f_m_req", m_req, 1);
    check("sim_f_addr", m_addr, 32'h0);
    check("sim_f_we", m_we, 0);
    tick();
    check("sim_if_ack", if_ack, 1);
    check("sim_if_rdata", if_rdata, 32'hA5A5_0001);
    idle(4);

    // starvation: fetch held, data re-requested every cycle
    use_fixed = 1'b0;
    drive_reqs(100, 100);
    n_d = 0; seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      tick();
      if (f_got) seen = 1'b1;
      else begin
        if (d_got) n_d++;
        drive_reqs(100, 100);
      end
    end
    check("starve_fetch_seen", seen, 1);
    check("starve_data_grants", n_d, MS);
    check("starve_streak_clr", dbg_streak, 0);
    drive_reqs(0, 0);
    idle(14);

    // timeout: fetch never acked
    lat_fixed = 100;
    if_req = 1'b1; if_addr = 32'h40;
    for (int k = 1; k <= T; k++) begin
      tick();
      check("tmo_m_req", m_req, 1);
    end
    tick();
    check("tmo_if_ack", if_ack, 1);
    check("tmo_err", err, 1);
    check("tmo_if_rdata", if_rdata, 0);
    idle(4);

    // ack arrives in the last cycle before abort
    lat_fixed = T; use_fixed = 1'b1; data_fixed = 32'h13;
    if_req = 1'b1; if_addr = 32'h44;
    for (int k = 1; k <= T; k++) begin
      tick();
      check("race_m_req", m_req, 1);
    end
    tick();
    check("race_if_ack", if_ack, 1);
    check("race_if_rdata", if_rdata, 32'h13);
    check("race_err", err, 0);
    idle(4);

    // reset in the middle of a slow load
    lat_fixed = 10; use_fixed = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_wdata = '0;
    tick();
    tick();
    check("pre_rst_m_req", m_req, 1);
    #2 reset = 1'b1;
    #1;
    check("arst_m_req", m_req, 0);
    check("arst_busy", busy, 0);
    check("arst_d_ack", d_ack, 0);
    check("arst_err", err, 0);
    check("arst_m_addr", m_addr, 0);
    check("arst_m_we", m_we, 0);
    check("arst_d_rdata", d_rdata, 0);
    check("arst_if_rdata", if_rdata, 0);
    check("arst_state", dbg_state, 0);
    d_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("arst_no_d_ack", d_ack, 0);
    end
    reset = 1'b0;
    lat_fixed = 1; use_fixed = 1'b1; data_fixed = 32'h1234_5678;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h104;
    tick();
    check("post_rst_m_req", m_req, 1);
    tick();
    check("post_rst_d_ack", d_ack, 1);
    check("post_rst_rdata", d_rdata, 32'h1234_5678);
    idle(4);

    // random traffic with random latencies (including timeouts and late acks)
    lat_fixed = 0; use_fixed = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      tick();
      drive_reqs(40, 40);
    end
    idle(12);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port to one-port memory arbiter that lets the pipelined core run from a single shared memory with variable latency. It sits between the core's instruction-fetch port, its MEM-stage load/store port, and one request/acknowledge memory bus. It serialises accesses and gives priority to data, with an anti-starvation counter for fetch. A per-access timeout converts a hung bus into an error completion.

## Interface
- XLEN, 32: address/data width.
- MAX_STREAK, 3: consecutive data grants allowed while fetch waits before fetch is forced; range 1..15.
- TIMEOUT, 255: cycles in a grant state without m_ack before abort; 0 disables; range 0..65535.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr stable until if_ack.
- if_addr  in  XLEN  fetch address.
- if_rdata  out  32  fetched instruction, low 32 bits of m_rdata.
- if_ack  out  1  one-cycle completion pulse.
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  XLEN  data address.
- d_wdata  in  XLEN  store data.
- d_rdata  out  XLEN  load data.
- d_ack  out  1  one-cycle completion pulse.
- m_req  out  1  bus request; held until m_ack or abort.
- m_we  out  1  bus write enable.
- m_addr  out  XLEN  bus address.
- m_wdata  out  XLEN  bus write data.
- m_rdata  in  XLEN  bus read data; valid when m_ack=1.
- m_ack  in  1  bus completion; sampled only while m_req=1.
- err  out  1  one-cycle pulse with the ack of an aborted access.
- busy  out  1  high in GRANT_I, GRANT_D and DONE.

## Operation
- FSM states: IDLE, GRANT_I, GRANT_D, DONE.
- IDLE, no requests: stay.
- IDLE, only d_req: go to GRANT_D.
- IDLE, only if_req: go to GRANT_I.
- IDLE, both requests: go to GRANT_D, unless streak == MAX_STREAK, in which case go to GRANT_I.
- The winner's m_we, m_addr and m_wdata are registered on entry to a grant state. For fetch, m_we=0 and m_wdata=0.
- streak: 4-bit counter.
  - Increments on a data grant made while if_req=1.
  - Clears on any fetch grant.
  - Clears on a data grant made while if_req=0.
  - Saturates at MAX_STREAK.
- GRANT_x with m_ack=1: completion.
  - Capture read data: a fetch loads if_rdata; a data load loads d_rdata; a store leaves d_rdata unchanged.
  - Clear tmo. Go to DONE with the port-x ack armed.
- GRANT_x with m_ack=0: tmo increments (16-bit).
- Abort: TIMEOUT≠0 and tmo == TIMEOUT-1 with m_ack=0.
  - Go to DONE with the port-x ack and err armed.
  - The rdata register for port x is loaded with 0 (a store leaves d_rdata unchanged).
  - If m_ack and the abort condition occur in the same cycle, m_ack wins: normal completion, no err.
- DONE: pulse x_ack (and err if armed) for exactly one cycle, with no arbitration. Go to IDLE. This prevents re-granting a request that is still held in the ack cycle.
- m_ack outside a grant state is ignored.
- if_ack and d_ack are never high together.

## Timing
- All outputs are registered. The ack and err pulses are driven from the DONE state.
- Reset values: state IDLE; m_req, m_we, if_ack, d_ack, err and busy are 0; m_addr, m_wdata, if_rdata and d_rdata are 0; streak and tmo are 0.
- Reset asserted mid-access drops m_req asynchronously. The in-flight access is abandoned and no ack is issued.
- Request sampled in IDLE at cycle 0:
  - m_req is high from cycle 1.
  - With m_ack at cycle k≥1, the ack is high at cycle k+1 and the state is IDLE at cycle k+2.
- Minimum access period: 3 cycles (IDLE, GRANT, DONE) with zero-wait memory.
- Timeout: with no m_ack, m_req stays high for exactly TIMEOUT cycles, then ack and err pulse in the next cycle.

## Test plan
- Single load: d_req, d_we=0, d_addr=0x100; m_ack in the first grant cycle with m_rdata=0xDEADBEEF.
  -> m_req high in cycle 1, d_ack and d_rdata=0xDEADBEEF in cycle 2, err=0.
- Simultaneous requests: if_req (0x0) and d_req (store, 0x200, 0x55) in IDLE, zero-wait memory.
  -> data granted first (m_we=1, m_addr=0x200), then fetch, with acks in cycles 2 and 5.
- Starvation: if_req held, d_req re-asserted every cycle with MAX_STREAK=3.
  -> exactly 3 data grants, then a fetch grant, then streak=0.
- Timeout: TIMEOUT=4, fetch to 0x40, m_ack never asserted.
  -> m_req high for cycles 1–4, if_ack=1, err=1 and if_rdata=0 in cycle 5.
- Ack/timeout race: TIMEOUT=4, m_ack=1 in cycle 4 with m_rdata=0x13.
  -> if_ack with if_rdata=0x13 and err=0.
- Reset mid-access: assert reset during GRANT_D with a 10-cycle memory latency.
  -> m_req=0 immediately, no d_ack, all outputs at reset values, and a new request after release is served normally.
